// File: rtl/scr1_tcm_pkg.sv
// ---------------------------------------------------------------------------
// scr1_tcm_pkg
// Shared types and helpers for the TCM port controller.
//   type_scr1_mem_width_e : request access width (BYTE/HWORD/WORD, 11 illegal)
//   type_scr1_mem_cmd_e   : request command (READ/WRITE)
//   scr1_tcm_legal        : alignment / width legality of a request
//   scr1_tcm_be           : byte enable for a width at a byte offset
//   scr1_tcm_wdata        : write data replicated onto all addressed lanes
//   scr1_tcm_rdata        : read data aligned down and zero-extended
// ---------------------------------------------------------------------------
package scr1_tcm_pkg;

  localparam int SCR1_TCM_NBYTES = 4;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  // A request is legal when it is naturally aligned for its width.
  function automatic logic scr1_tcm_legal(type_scr1_mem_width_e width,
                                          logic [1:0]           offset);
    case (width)
      SCR1_MEM_WIDTH_BYTE:  return 1'b1;
      SCR1_MEM_WIDTH_HWORD: return ~offset[0];
      SCR1_MEM_WIDTH_WORD:  return (offset == 2'b00);
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [SCR1_TCM_NBYTES-1:0] scr1_tcm_be(type_scr1_mem_width_e width,
                                                             logic [1:0]           offset);
    case (width)
      SCR1_MEM_WIDTH_BYTE:  return 4'b0001 << offset;
      SCR1_MEM_WIDTH_HWORD: return 4'b0011 << offset;
      SCR1_MEM_WIDTH_WORD:  return 4'b1111;
      default:              return 4'b0000;
    endcase
  endfunction

  // Replicating the data means every lane already carries the right byte,
  // so only the byte enable has to depend on the offset.
  function automatic logic [31:0] scr1_tcm_wdata(type_scr1_mem_width_e width,
                                                 logic [31:0]          wdata);
    case (width)
      SCR1_MEM_WIDTH_BYTE:  return {4{wdata[7:0]}};
      SCR1_MEM_WIDTH_HWORD: return {2{wdata[15:0]}};
      default:              return wdata;
    endcase
  endfunction

  function automatic logic [31:0] scr1_tcm_rdata(type_scr1_mem_width_e width,
                                                 logic [1:0]           offset,
                                                 logic [31:0]          qdata);
    logic [31:0] shifted;
    shifted = qdata >> {offset, 3'b000};
    case (width)
      SCR1_MEM_WIDTH_BYTE:  return {24'h000000, shifted[7:0]};
      SCR1_MEM_WIDTH_HWORD: return {16'h0000, shifted[15:0]};
      default:              return shifted;
    endcase
  endfunction

endpackage

// File: rtl/scr1_tcm_port_ctrl.sv
// ---------------------------------------------------------------------------
// scr1_tcm_port_ctrl
// Drives port B of the dual-port TCM from the core data-memory request
// interface. One response is returned per accepted request, one cycle after
// acceptance; a stalled response blocks new acceptances.
//   clk, rst             : core clock, asynchronous active-high reset
//   req/req_ack          : request handshake (req_ack independent of req)
//   req_cmd/width/addr   : command, access width, byte address
//   req_wdata            : LSB-justified write data
//   resp_valid/ready     : response handshake
//   resp_err/resp_rdata  : error flag, aligned zero-extended read data
//   mem_*                : memory port B (renb, wenb, webb, addrb, datab, qb)
// ---------------------------------------------------------------------------
module scr1_tcm_port_ctrl
  import scr1_tcm_pkg::*;
#(
  parameter int AWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              req_ack,
  input  logic              req_cmd,
  input  logic [1:0]        req_width,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [3:0]        mem_wbe,
  output logic [AWIDTH-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_qdata
);

  type_scr1_mem_width_e req_width_e;
  type_scr1_mem_cmd_e   req_cmd_e;
  logic                 accept;
  logic                 legal;

  type_scr1_mem_cmd_e   resp_cmd_q;
  type_scr1_mem_width_e resp_width_q;
  logic [1:0]           resp_off_q;
  logic                 resp_err_q;

  assign req_width_e = type_scr1_mem_width_e'(req_width);
  assign req_cmd_e   = type_scr1_mem_cmd_e'(req_cmd);

  // Holding off acceptance while a response is stalled keeps mem_qdata
  // (and therefore resp_rdata) frozen, since no new read is launched.
  assign req_ack = ~rst & (~resp_valid | resp_ready);
  assign accept  = req & req_ack;
  assign legal   = scr1_tcm_legal(req_width_e, req_addr[1:0]);

  assign mem_ren   = accept & legal & (req_cmd_e == SCR1_MEM_CMD_RD);
  assign mem_wen   = accept & legal & (req_cmd_e == SCR1_MEM_CMD_WR);
  assign mem_addr  = req_addr[AWIDTH-1:2];
  assign mem_wbe   = scr1_tcm_be(req_width_e, req_addr[1:0]);
  assign mem_wdata = scr1_tcm_wdata(req_width_e, req_wdata);

  // Response state is captured at acceptance. A new acceptance takes
  // priority over a consume, so resp_valid stays high across back-to-back
  // transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid   <= 1'b0;
      resp_cmd_q   <= SCR1_MEM_CMD_RD;
      resp_width_q <= SCR1_MEM_WIDTH_BYTE;
      resp_off_q   <= 2'b00;
      resp_err_q   <= 1'b0;
    end else if (accept) begin
      resp_valid   <= 1'b1;
      resp_cmd_q   <= req_cmd_e;
      resp_width_q <= req_width_e;
      resp_off_q   <= req_addr[1:0];
      resp_err_q   <= ~legal;
    end else if (resp_valid & resp_ready) begin
      resp_valid   <= 1'b0;
    end
  end

  assign resp_err = resp_valid & resp_err_q;

  // Read data is aligned straight from the memory output register; writes
  // and errors return zero.
  always_comb begin
    resp_rdata = 32'h0000_0000;
    if (resp_valid & ~resp_err_q & (resp_cmd_q == SCR1_MEM_CMD_RD)) begin
      resp_rdata = scr1_tcm_rdata(resp_width_q, resp_off_q, mem_qdata);
    end
  end

endmodule

// File: tb/tb_scr1_tcm_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scr1_tcm_port_ctrl
// Directed bench for scr1_tcm_port_ctrl with a behavioural TCM on port B.
// Expected responses are pushed to a scoreboard queue when a request is
// driven and popped by a monitor when the response is consumed.
// ---------------------------------------------------------------------------
module tb_scr1_tcm_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        req_ack;
  logic        req_cmd;
  logic [1:0]  req_width;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_ren;
  logic        mem_wen;
  logic [3:0]  mem_wbe;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_qdata = 32'h0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } sb_entry_t;

  sb_entry_t   sb[$];
  logic [7:0]  shadow [int];
  logic [31:0] tcm [0:16383] = '{default: 32'h0};
  int          check_count = 0;
  int          pass_count  = 0;
  bit          prev_accepted = 1'b0;
  logic [31:0] stall_exp;

  scr1_tcm_port_ctrl #(.AWIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_ack    (req_ack),
    .req_cmd    (req_cmd),
    .req_width  (req_width),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_wbe    (mem_wbe),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_qdata  (mem_qdata)
  );

  always #5 clk = ~clk;

  // Behavioural TCM port B: byte-masked write, registered read held while
  // renb is low.
  always @(posedge clk) begin
    if (mem_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wbe[b]) tcm[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (mem_ren) mem_qdata <= tcm[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int sizeOf(input logic [1:0] w);
    case (w)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit isLegal(input logic [1:0] w, input logic [15:0] a);
    return (w == 2'b00) || (w == 2'b01 && !a[0]) || (w == 2'b10 && a[1:0] == 2'b00);
  endfunction

  function automatic logic [3:0] expWbe(input logic [1:0] w, input logic [15:0] a);
    int off = int'(a[1:0]);
    logic [3:0] be = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + sizeOf(w)) be[i] = 1'b1;
    end
    return be;
  endfunction

  function automatic logic [31:0] expWdata(input logic [1:0] w, input logic [31:0] d);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = d[8*(i % sizeOf(w)) +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] expRead(input logic [1:0] w, input logic [15:0] a);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < sizeOf(w); i++) begin
      r[8*i +: 8] = shadow.exists(int'(a) + i) ? shadow[int'(a) + i] : 8'h00;
    end
    return r;
  endfunction

  // Consumes responses and compares them against the scoreboard.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_resp", {31'h0, resp_valid}, 32'h0);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        checkOutput("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        checkOutput("resp_rdata", resp_rdata, e.rdata);
      end
    end
  end

  // Drives one request that must be accepted this cycle, checks the port B
  // strobes and records the expected response.
  task automatic applyStimulus(input logic cmd, input logic [1:0] w,
                               input logic [15:0] a, input logic [31:0] d);
    bit        legal;
    sb_entry_t e;
    req = 1'b1; req_cmd = cmd; req_width = w; req_addr = a; req_wdata = d;
    legal = isLegal(w, a);
    @(negedge clk);
    if (prev_accepted) checkOutput("latency_valid", {31'h0, resp_valid}, 32'h1);
    checkOutput("req_ack", {31'h0, req_ack}, 32'h1);
    checkOutput("mem_ren", {31'h0, mem_ren}, {31'h0, legal && !cmd});
    checkOutput("mem_wen", {31'h0, mem_wen}, {31'h0, legal && cmd});
    if (legal) begin
      checkOutput("mem_addr", {18'h0, mem_addr}, {18'h0, a[15:2]});
      if (cmd) begin
        checkOutput("mem_wbe", {28'h0, mem_wbe}, {28'h0, expWbe(w, a)});
        checkOutput("mem_wdata", mem_wdata, expWdata(w, d));
      end
    end
    e.err   = !legal;
    e.rdata = (legal && !cmd) ? expRead(w, a) : 32'h0;
    sb.push_back(e);
    if (legal && cmd) begin
      for (int i = 0; i < sizeOf(w); i++) shadow[int'(a) + i] = d[8*i +: 8];
    end
    prev_accepted = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idleCycles(input int n);
    req = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (prev_accepted) checkOutput("latency_valid", {31'h0, resp_valid}, 32'h1);
      prev_accepted = 1'b0;
      checkOutput("idle_strobes", {30'h0, mem_ren, mem_wen}, 32'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; req = 1'b1; req_cmd = 1'b0; req_width = 2'b10;
    req_addr = 16'h0; req_wdata = 32'h0; resp_ready = 1'b1;

    // Reset state, with a request pending to exercise req_ack gating.
    #3;
    checkOutput("rst_req_ack", {31'h0, req_ack}, 32'h0);
    checkOutput("rst_mem_ren", {31'h0, mem_ren}, 32'h0);
    checkOutput("rst_mem_wen", {31'h0, mem_wen}, 32'h0);
    checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("rst_resp_err", {31'h0, resp_err}, 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    @(posedge clk); #1;

    // Reset asserted while a response is stalled.
    resp_ready = 1'b0;
    applyStimulus(1'b0, 2'b10, 16'h0020, 32'h0);
    req = 1'b0;
    @(negedge clk);
    checkOutput("stall_valid", {31'h0, resp_valid}, 32'h1);
    #2;
    rst = 1'b1; req = 1'b1;
    #1;
    checkOutput("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("midrst_req_ack", {31'h0, req_ack}, 32'h0);
    checkOutput("midrst_mem_ren", {31'h0, mem_ren}, 32'h0);
    checkOutput("midrst_mem_wen", {31'h0, mem_wen}, 32'h0);
    sb.delete();
    prev_accepted = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0; resp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_rst_no_resp", {31'h0, resp_valid}, 32'h0);
      @(posedge clk); #1;
    end

    // Word write then word read back.
    applyStimulus(1'b1, 2'b10, 16'h0010, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 16'h0010, 32'h0);
    idleCycles(2);

    // Byte write into the top lane, then byte and halfword reads.
    applyStimulus(1'b1, 2'b00, 16'h0013, 32'h000000A5);
    applyStimulus(1'b0, 2'b00, 16'h0013, 32'h0);
    applyStimulus(1'b0, 2'b01, 16'h0012, 32'h0);
    idleCycles(2);

    // Misaligned and illegal-width requests.
    applyStimulus(1'b0, 2'b01, 16'h0001, 32'h0);
    applyStimulus(1'b0, 2'b10, 16'h0002, 32'h0);
    applyStimulus(1'b1, 2'b11, 16'h0000, 32'h12345678);
    idleCycles(2);

    // Halfword write to another word, then back-to-back reads.
    applyStimulus(1'b1, 2'b01, 16'h0042, 32'h0000C3D2);
    applyStimulus(1'b0, 2'b10, 16'h0040, 32'h0);
    applyStimulus(1'b0, 2'b01, 16'h0012, 32'h0);
    applyStimulus(1'b0, 2'b00, 16'h0011, 32'h0);
    idleCycles(2);

    // Stalled response: further requests held off, read data frozen.
    applyStimulus(1'b0, 2'b10, 16'h0010, 32'h0);
    stall_exp = sb[$].rdata;
    resp_ready = 1'b0;
    req = 1'b1; req_cmd = 1'b0; req_width = 2'b10; req_addr = 16'h0080;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_req_ack", {31'h0, req_ack}, 32'h0);
      checkOutput("stall_mem_ren", {31'h0, mem_ren}, 32'h0);
      checkOutput("stall_resp_valid", {31'h0, resp_valid}, 32'h1);
      checkOutput("stall_rdata", resp_rdata, stall_exp);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    applyStimulus(1'b0, 2'b10, 16'h0080, 32'h0);
    idleCycles(2);

    checkOutput("sb_drained", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
